// File: rtl/everloop_scheduler.sv
// -----------------------------------------------------------------------------
// everloop_scheduler
//
// Sole master of the everloop frame RAM write port (port A). Shares that port
// between a host byte-write requester and an internal spinner animation engine
// that rewrites the whole LED frame once per frame period with one lit LED.
// Each LED takes four bytes. The lit LED moves one step around the ring after
// every completed frame.
//
// Ports:
//   clk, rst     system clock, asynchronous active-low reset
//   anim_en      level; enables the animation engine (low aborts a frame)
//   anim_dir     0: head increments, 1: head decrements (sampled in DONE)
//   anim_color   lit LED color; [31:24] goes to byte offset 0 ... [7:0] to 3
//   host_req     host write request, held until host_ack
//   host_adr     host byte address
//   host_dat     host write data
//   host_ack     one-cycle pulse; the host write is on the RAM port this cycle
//   ram_en       port A enable      (registered)
//   ram_we       port A write enable (registered, equal to ram_en)
//   ram_adr      port A address     (holds its value when idle)
//   ram_dat      port A write data  (holds its value when idle)
//   frame_done   one-cycle pulse after the last byte of a frame
//   overrun      sticky; a frame tick arrived while one was pending
//   head         index of the currently lit LED
// -----------------------------------------------------------------------------
module everloop_scheduler #(
    parameter int          NUM_LEDS  = 35,
    parameter logic [23:0] FRAME_DIV = 24'd1_000_000,
    parameter int          ADR_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 anim_en,
    input  logic                 anim_dir,
    input  logic [31:0]          anim_color,
    input  logic                 host_req,
    input  logic [ADR_WIDTH-1:0] host_adr,
    input  logic [7:0]           host_dat,
    output logic                 host_ack,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADR_WIDTH-1:0] ram_adr,
    output logic [7:0]           ram_dat,
    output logic                 frame_done,
    output logic                 overrun,
    output logic [5:0]           head
);

    localparam int NUM_BYTES = NUM_LEDS * 4;
    localparam int BC_W      = $clog2(NUM_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
    typedef enum logic       {GNT_ENGINE, GNT_HOST}   grant_t;

    state_t                 state_q,      state_d;
    grant_t                 last_q,       last_d;
    logic [23:0]            timer_q,      timer_d;
    logic                   pending_q,    pending_d;
    logic                   overrun_q,    overrun_d;
    logic [BC_W-1:0]        bc_q,         bc_d;
    logic [31:0]            col_q,        col_d;
    logic [5:0]             head_q,       head_d;
    logic                   host_ack_q,   host_ack_d;
    logic                   ram_en_q,     ram_en_d;
    logic [ADR_WIDTH-1:0]   ram_adr_q,    ram_adr_d;
    logic [7:0]             ram_dat_q,    ram_dat_d;
    logic                   frame_done_q, frame_done_d;

    logic       tick;
    logic       eng_req;
    logic       host_gnt;
    logic       eng_gnt;
    logic       eng_on_head;
    logic [7:0] eng_dat;

    assign tick        = anim_en && (timer_q == FRAME_DIV - 24'd1);
    // The engine stops requesting the moment anim_en falls, so an abort never
    // produces one more engine write.
    assign eng_req     = (state_q == S_FILL) && anim_en;
    // Round-robin: on a conflict the host wins only if the engine went last.
    assign host_gnt    = host_req && (!eng_req || (last_q == GNT_ENGINE));
    assign eng_gnt     = eng_req && !host_gnt;
    assign eng_on_head = ((32'(bc_q)) >> 2) == 32'(head_q);

    always_comb begin
        // NOTE: every variable gets a default before any branch, so no path
        // through this block can leave one unassigned and infer a latch.
        eng_dat = 8'h00;
        if (eng_on_head) begin
            case (bc_q[1:0])
                2'd0:    eng_dat = col_q[31:24];
                2'd1:    eng_dat = col_q[23:16];
                2'd2:    eng_dat = col_q[15:8];
                default: eng_dat = col_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        timer_d      = timer_q;
        pending_d    = pending_q;
        overrun_d    = overrun_q;
        bc_d         = bc_q;
        col_d        = col_q;
        head_d       = head_q;
        host_ack_d   = 1'b0;
        ram_en_d     = 1'b0;
        ram_adr_d    = ram_adr_q;
        ram_dat_d    = ram_dat_q;
        frame_done_d = 1'b0;

        // Frame timer and tick bookkeeping; disabling clears all of it.
        if (!anim_en) begin
            timer_d   = 24'd0;
            pending_d = 1'b0;
            overrun_d = 1'b0;
        end else if (tick) begin
            timer_d = 24'd0;
            if (pending_q) overrun_d = 1'b1;
            else           pending_d = 1'b1;
        end else begin
            timer_d = timer_q + 24'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (anim_en && pending_q) begin
                    state_d   = S_FILL;
                    pending_d = 1'b0;
                    col_d     = anim_color;
                    bc_d      = '0;
                end
            end
            S_FILL: begin
                if (!anim_en) begin
                    state_d = S_IDLE;
                end else if (eng_gnt) begin
                    if (bc_q == BC_W'(NUM_BYTES - 1)) state_d = S_DONE;
                    else                               bc_d    = bc_q + BC_W'(1);
                end
            end
            S_DONE: begin
                frame_done_d = 1'b1;
                state_d      = S_IDLE;
                if (!anim_dir) head_d = (head_q == 6'(NUM_LEDS - 1)) ? 6'd0 : head_q + 6'd1;
                else           head_d = (head_q == 6'd0) ? 6'(NUM_LEDS - 1) : head_q - 6'd1;
            end
            default: state_d = S_IDLE;
        endcase

        if (host_gnt) begin
            host_ack_d = 1'b1;
            ram_en_d   = 1'b1;
            ram_adr_d  = host_adr;
            ram_dat_d  = host_dat;
            last_d     = GNT_HOST;
        end else if (eng_gnt) begin
            ram_en_d   = 1'b1;
            ram_adr_d  = ADR_WIDTH'(bc_q);
            ram_dat_d  = eng_dat;
            last_d     = GNT_ENGINE;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            last_q       <= GNT_ENGINE;
            timer_q      <= 24'd0;
            pending_q    <= 1'b0;
            overrun_q    <= 1'b0;
            bc_q         <= '0;
            col_q        <= 32'd0;
            head_q       <= 6'd0;
            host_ack_q   <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_adr_q    <= '0;
            ram_dat_q    <= 8'd0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            timer_q      <= timer_d;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            bc_q         <= bc_d;
            col_q        <= col_d;
            head_q       <= head_d;
            host_ack_q   <= host_ack_d;
            ram_en_q     <= ram_en_d;
            ram_adr_q    <= ram_adr_d;
            ram_dat_q    <= ram_dat_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign host_ack   = host_ack_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_en_q;
    assign ram_adr    = ram_adr_q;
    assign ram_dat    = ram_dat_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign head       = head_q;

endmodule
